// File: rtl/dac_wave_generator_if.sv
// Sample handshake bundle between dac_wave_generator and the LTC2624 SPI adapter.
// The master side presents the FIFO head sample; the slave side accepts it with READY.
interface dac_wave_generator_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] SAMPLE_DATA;
  logic [3:0]            SAMPLE_CHANNEL;
  logic [3:0]            SAMPLE_COMMAND;
  logic                  SAMPLE_VALID;
  logic                  SAMPLE_READY;

  modport master (
    output SAMPLE_DATA,
    output SAMPLE_CHANNEL,
    output SAMPLE_COMMAND,
    output SAMPLE_VALID,
    input  SAMPLE_READY
  );

  modport slave (
    input  SAMPLE_DATA,
    input  SAMPLE_CHANNEL,
    input  SAMPLE_COMMAND,
    input  SAMPLE_VALID,
    output SAMPLE_READY
  );
endinterface

// File: rtl/dac_wave_generator.sv
// dac_wave_generator: sawtooth / triangle / square / constant sample source for
// the LTC2624 DAC adapter. A divider produces a sample tick every SAMPLE_DIV
// clocks; each tick pushes one sample (with its channel) into a small FIFO whose
// head is offered downstream over a valid/ready handshake.
// Optional build macro DAC_WAVE_BACKPRESSURE_EN: when defined, a tick that would
// find the FIFO full (and no pop) is held off instead of dropping the sample, so
// OVERRUN is constant 0. Undefined (default): the sample is dropped, the phase
// still advances and the sticky OVERRUN flag is set.
module dac_wave_generator #(
  parameter int SAMPLE_DIV = 50000,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               SYSTEM_CLOCK,
  input  logic                               RESET_N,
  input  logic                               ENABLE,
  input  logic [1:0]                         MODE,
  input  logic [DATA_WIDTH-1:0]              STEP,
  input  logic [DATA_WIDTH-1:0]              LEVEL,
  input  logic [3:0]                         CHANNEL,
  output logic                               OVERRUN,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_LEVEL,
  dac_wave_generator_if.master               sample_bus
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_WIDTH + 4;

  localparam logic [CW-1:0]         CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [LW-1:0]         LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic                  DIR_UP   = 1'b0;
  localparam logic                  DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    MODE_SAW   = 2'b00,
    MODE_TRI   = 2'b01,
    MODE_SQR   = 2'b10,
    MODE_CONST = 2'b11
  } mode_e;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] phase_q, phase_d;
  logic                  dir_q, dir_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overrun_q, overrun_d;

  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]         head_entry;

  logic                  tick_at_last;
  logic                  stall;
  logic                  tick;
  logic                  valid;
  logic                  pop;
  logic                  full;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH:0]   tri_sum;

  // Tick qualification and FIFO push/pop decisions for this cycle.
  always_comb begin
    tick_at_last = ENABLE && (cnt_q == CNT_LAST);
    valid        = (level_q != '0);
    pop          = valid && sample_bus.SAMPLE_READY;
    full         = (level_q == LVL_FULL);
`ifdef DAC_WAVE_BACKPRESSURE_EN
    stall        = tick_at_last && full && !pop;
`else
    stall        = 1'b0;
`endif
    tick         = tick_at_last && !stall;
    push         = tick && (!full || pop);
  end

  // Sample-rate divider: cleared while disabled, held at the last count while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (!ENABLE) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Waveform phase update and the value pushed on a tick (taken from the old phase).
  always_comb begin
    phase_d   = phase_q;
    dir_d     = dir_q;
    push_data = phase_q;
    tri_sum   = {1'b0, phase_q} + {1'b0, STEP};
    if (tick) begin
      case (mode_e'(MODE))
        MODE_SAW: begin
          push_data = phase_q;
          phase_d   = phase_q + STEP;
        end
        MODE_TRI: begin
          push_data = phase_q;
          if (dir_q == DIR_UP) begin
            if (tri_sum >= {1'b0, MAX_VAL}) begin
              phase_d = MAX_VAL;
              dir_d   = DIR_DOWN;
            end else begin
              phase_d = tri_sum[DATA_WIDTH-1:0];
            end
          end else begin
            if (phase_q <= STEP) begin
              phase_d = '0;
              dir_d   = DIR_UP;
            end else begin
              phase_d = phase_q - STEP;
            end
          end
        end
        MODE_SQR: begin
          push_data = phase_q[DATA_WIDTH-1] ? LEVEL : '0;
          phase_d   = phase_q + STEP;
        end
        default: begin
          push_data = LEVEL;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
`ifdef DAC_WAVE_BACKPRESSURE_EN
    overrun_d = 1'b0;
`else
    overrun_d = overrun_q | (tick && full && !pop);
`endif
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge SYSTEM_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q     <= '0;
      phase_q   <= '0;
      dir_q     <= DIR_UP;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // Sample storage; contents only matter behind a valid level, so no reset is needed.
  always_ff @(posedge SYSTEM_CLOCK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {CHANNEL, push_data};
    end
  end

  // Head presentation: zeros whenever the FIFO is empty so reset/empty outputs are clean.
  always_comb begin
    head_entry                = fifo_mem[rd_ptr_q];
    sample_bus.SAMPLE_VALID   = valid;
    sample_bus.SAMPLE_DATA    = valid ? head_entry[DATA_WIDTH-1:0] : '0;
    sample_bus.SAMPLE_CHANNEL = valid ? head_entry[EW-1:DATA_WIDTH] : 4'h0;
    sample_bus.SAMPLE_COMMAND = 4'b0011;
  end

  assign OVERRUN    = overrun_q;
  assign FIFO_LEVEL = level_q;

endmodule

// File: tb/tb_dac_wave_generator.sv
// Directed testbench for dac_wave_generator with SAMPLE_DIV=4, FIFO_DEPTH=4.
// A table of waveform vectors drives the main sample checks; hand-written
// sequences cover reset, latency, overrun, full-with-pop, async reset and enable gating.
module tb_dac_wave_generator;

  localparam int DW = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [DW-1:0]  step = '0;
  logic [DW-1:0]  level = '0;
  logic [3:0]     channel = 4'h0;
  logic           overrun;
  logic [2:0]     fifo_level;

  int checks = 0;
  int errors = 0;

  dac_wave_generator_if #(.DATA_WIDTH(DW)) sample_bus ();

  dac_wave_generator #(
    .SAMPLE_DIV(4),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(4)
  ) dut (
    .SYSTEM_CLOCK(clk),
    .RESET_N(rst_n),
    .ENABLE(enable),
    .MODE(mode),
    .STEP(step),
    .LEVEL(level),
    .CHANNEL(channel),
    .OVERRUN(overrun),
    .FIFO_LEVEL(fifo_level),
    .sample_bus(sample_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          do_rst;
    logic [1:0]    mode;
    logic [DW-1:0] step;
    logic [DW-1:0] level;
    logic [3:0]    chan;
    logic [DW-1:0] exp_data;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

`ifdef DAC_WAVE_BACKPRESSURE_EN
  localparam logic       EXP_OVR  = 1'b0;
  localparam logic [11:0] EXP_NEXT = 12'h000;
`else
  localparam logic       EXP_OVR  = 1'b1;
  localparam logic [11:0] EXP_NEXT = 12'h400;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
  endtask

  // Waits (bounded) at negedges for VALID; a timeout is a failed comparison.
  task automatic wait_valid(input string name);
    for (int i = 0; i < 40 && !sample_bus.SAMPLE_VALID; i++) @(negedge clk);
    checks++;
    if (!sample_bus.SAMPLE_VALID) begin
      errors++;
      $display("FAIL %s: got VALID=0 expected VALID=1 within 40 cycles", name);
    end
  endtask

  // With READY=1: wait for the head, check it, let it pop and return at a negedge.
  task automatic pop_check(input string name, input logic [DW-1:0] exp);
    wait_valid({name, "_wait"});
    check({name, "_data"}, 32'(sample_bus.SAMPLE_DATA), 32'(exp));
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] m, input logic [DW-1:0] s,
                              input logic [DW-1:0] l, input logic [3:0] c, input logic [DW-1:0] e);
    vec_t v;
    v.do_rst = r; v.mode = m; v.step = s; v.level = l; v.chan = c; v.exp_data = e;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Sawtooth (reset first)
    vecs[0]  = mk(1'b1, 2'b00, 12'h400, 12'h000, 4'h2, 12'h000);
    vecs[1]  = mk(1'b0, 2'b00, 12'h400, 12'h000, 4'h2, 12'h400);
    vecs[2]  = mk(1'b0, 2'b00, 12'h400, 12'h000, 4'h2, 12'h800);
    vecs[3]  = mk(1'b0, 2'b00, 12'h400, 12'h000, 4'h2, 12'hC00);
    vecs[4]  = mk(1'b0, 2'b00, 12'h400, 12'h000, 4'h2, 12'h000);
    // Triangle (reset first)
    vecs[5]  = mk(1'b1, 2'b01, 12'h600, 12'h000, 4'h5, 12'h000);
    vecs[6]  = mk(1'b0, 2'b01, 12'h600, 12'h000, 4'h5, 12'h600);
    vecs[7]  = mk(1'b0, 2'b01, 12'h600, 12'h000, 4'h5, 12'hC00);
    vecs[8]  = mk(1'b0, 2'b01, 12'h600, 12'h000, 4'h5, 12'hFFF);
    vecs[9]  = mk(1'b0, 2'b01, 12'h600, 12'h000, 4'h5, 12'h9FF);
    vecs[10] = mk(1'b0, 2'b01, 12'h600, 12'h000, 4'h5, 12'h3FF);
    vecs[11] = mk(1'b0, 2'b01, 12'h600, 12'h000, 4'h5, 12'h000);
    vecs[12] = mk(1'b0, 2'b01, 12'h600, 12'h000, 4'h5, 12'h600);
    // Square (reset first), then constant, then sawtooth from the retained phase (0)
    vecs[13] = mk(1'b1, 2'b10, 12'h800, 12'h123, 4'h9, 12'h000);
    vecs[14] = mk(1'b0, 2'b10, 12'h800, 12'h123, 4'h9, 12'h123);
    vecs[15] = mk(1'b0, 2'b10, 12'h800, 12'h123, 4'h9, 12'h000);
    vecs[16] = mk(1'b0, 2'b10, 12'h800, 12'h123, 4'h9, 12'h123);
    vecs[17] = mk(1'b0, 2'b11, 12'h100, 12'h0AB, 4'h9, 12'h0AB);
    vecs[18] = mk(1'b0, 2'b11, 12'h100, 12'h0AB, 4'h9, 12'h0AB);
    vecs[19] = mk(1'b0, 2'b00, 12'h100, 12'h0AB, 4'hA, 12'h000);
    vecs[20] = mk(1'b0, 2'b00, 12'h100, 12'h0AB, 4'hA, 12'h100);

    sample_bus.SAMPLE_READY = 1'b0;

    // Reset state and one-cycle push latency
    do_reset();
    check("rst_valid",   32'(sample_bus.SAMPLE_VALID),   32'h0);
    check("rst_data",    32'(sample_bus.SAMPLE_DATA),    32'h0);
    check("rst_channel", 32'(sample_bus.SAMPLE_CHANNEL), 32'h0);
    check("rst_command", 32'(sample_bus.SAMPLE_COMMAND), 32'h3);
    check("rst_overrun", 32'(overrun),                   32'h0);
    check("rst_level",   32'(fifo_level),                32'h0);
    mode = 2'b00; step = 12'h400; channel = 4'h2; enable = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_before_tick_valid", 32'(sample_bus.SAMPLE_VALID), 32'h0);
    @(negedge clk);
    check("lat_after_tick_valid", 32'(sample_bus.SAMPLE_VALID), 32'h1);
    check("lat_after_tick_level", 32'(fifo_level), 32'h1);
    check("lat_after_tick_chan",  32'(sample_bus.SAMPLE_CHANNEL), 32'h2);

    // Table-driven waveform vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_rst) do_reset();
      mode = vecs[i].mode; step = vecs[i].step; level = vecs[i].level;
      channel = vecs[i].chan; sample_bus.SAMPLE_READY = 1'b1; enable = 1'b1;
      wait_valid($sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_data", i), 32'(sample_bus.SAMPLE_DATA), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_chan", i), 32'(sample_bus.SAMPLE_CHANNEL), 32'(vecs[i].chan));
      check($sformatf("vec%0d_cmd", i),  32'(sample_bus.SAMPLE_COMMAND), 32'h3);
      @(posedge clk);
      @(negedge clk);
    end

    // Overrun: five ticks with READY=0, then drain
    do_reset();
    sample_bus.SAMPLE_READY = 1'b0;
    mode = 2'b00; step = 12'h400; channel = 4'h2; enable = 1'b1;
    repeat (20) @(negedge clk);
    check("ovr_level_full", 32'(fifo_level), 32'h4);
    check("ovr_flag",       32'(overrun),    32'(EXP_OVR));
    enable = 1'b0;
    sample_bus.SAMPLE_READY = 1'b1;
    pop_check("ovr_pop0", 12'h000);
    pop_check("ovr_pop1", 12'h400);
    pop_check("ovr_pop2", 12'h800);
    pop_check("ovr_pop3", 12'hC00);
    check("ovr_level_empty", 32'(fifo_level), 32'h0);
    check("ovr_flag_sticky", 32'(overrun),    32'(EXP_OVR));
    enable = 1'b1;
    pop_check("ovr_next", EXP_NEXT);

    // Full FIFO with a pop on the tick edge: push accepted, level unchanged
    do_reset();
    sample_bus.SAMPLE_READY = 1'b0;
    mode = 2'b00; step = 12'h400; channel = 4'h3; enable = 1'b1;
    repeat (19) @(negedge clk);
    check("fp_level_before", 32'(fifo_level), 32'h4);
    sample_bus.SAMPLE_READY = 1'b1;
    @(negedge clk);
    sample_bus.SAMPLE_READY = 1'b0;
    check("fp_level_after", 32'(fifo_level), 32'h4);
    check("fp_overrun",     32'(overrun),    32'h0);
    check("fp_head",        32'(sample_bus.SAMPLE_DATA), 32'h400);
    enable = 1'b0;
    sample_bus.SAMPLE_READY = 1'b1;
    pop_check("fp_pop0", 12'h400);
    pop_check("fp_pop1", 12'h800);
    pop_check("fp_pop2", 12'hC00);
    pop_check("fp_pop3", 12'h000);

    // Asynchronous reset mid-operation with three samples queued
    do_reset();
    sample_bus.SAMPLE_READY = 1'b0;
    mode = 2'b00; step = 12'h400; channel = 4'h4; enable = 1'b1;
    repeat (12) @(negedge clk);
    check("ar_level_before", 32'(fifo_level), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_async", 32'(sample_bus.SAMPLE_VALID), 32'h0);
    check("ar_level_async", 32'(fifo_level),              32'h0);
    check("ar_data_async",  32'(sample_bus.SAMPLE_DATA),  32'h0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'b01; step = 12'h600; channel = 4'h7;
    sample_bus.SAMPLE_READY = 1'b1; enable = 1'b1;
    pop_check("ar_tri0", 12'h000);
    pop_check("ar_tri1", 12'h600);

    // ENABLE low for 20 cycles: no pushes, phase retained
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("en_off_level", 32'(fifo_level),              32'h0);
    check("en_off_valid", 32'(sample_bus.SAMPLE_VALID), 32'h0);
    enable = 1'b1;
    pop_check("en_resume", 12'hC00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_wave_generator.md
Name: dac_wave_generator

Overview:
- Upstream sample source for the LTC2624 DAC SPI adapter.
- Produces 12-bit samples (sawtooth, triangle, square or constant) at a programmable rate derived from SYSTEM_CLOCK.
- Buffers the samples in a small FIFO.
- Presents each sample with its channel and command nibble to the DAC adapter over a valid/ready handshake.

Parameters:
- SAMPLE_DIV, 50000, SYSTEM_CLOCK cycles per sample tick (>=2); 1 kHz at 50 MHz.
- DATA_WIDTH, 12, sample width; MAX = 2^DATA_WIDTH-1.
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, >=2).

Ports:
- SYSTEM_CLOCK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  high = generate samples on ticks.
- MODE  in  2  00 sawtooth, 01 triangle, 10 square, 11 constant.
- STEP  in  DATA_WIDTH  phase increment per tick.
- LEVEL  in  DATA_WIDTH  square high level / constant value.
- CHANNEL  in  4  DAC address nibble attached to each sample.
- SAMPLE_DATA  out  DATA_WIDTH  FIFO head sample.
- SAMPLE_CHANNEL  out  4  channel captured with the head sample.
- SAMPLE_COMMAND  out  4  always 4'b0011 (write and update).
- SAMPLE_VALID  out  1  FIFO non-empty.
- SAMPLE_READY  in  1  downstream accepts head when high with VALID.
- OVERRUN  out  1  sticky: a sample was dropped.
- FIFO_LEVEL  out  clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (RESET_N low, asynchronous): all of the following clear at once.
  - Outputs: SAMPLE_DATA=0, SAMPLE_CHANNEL=0, SAMPLE_VALID=0, OVERRUN=0, FIFO_LEVEL=0; SAMPLE_COMMAND=4'b0011 at all times.
  - Internal state: tick counter=0, phase P=0, DIR=up, FIFO emptied.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while ENABLE=1; TICK is asserted on the cycle where count==SAMPLE_DIV-1, then the counter wraps to 0.
  - ENABLE=0 holds the counter at 0. P, DIR and FIFO contents are retained, and the FIFO keeps draining.
- On TICK:
  - The push value is computed from P before update, and CHANNEL is captured alongside it.
  - P then updates per MODE:
    - Sawtooth: push P; P <= (P+STEP) mod 2^DATA_WIDTH.
    - Triangle, DIR up: push P; if P+STEP >= MAX then P<=MAX and DIR<=down, else P<=P+STEP.
    - Triangle, DIR down: push P; if P <= STEP then P<=0 and DIR<=up, else P<=P-STEP.
    - Square: push (P[MSB] ? LEVEL : 0); P advances as sawtooth.
    - Constant: push LEVEL; P unchanged.
- MODE, STEP and LEVEL are sampled at each tick; a change never resets P or DIR.
- FIFO and handshake:
  - Write occurs on the TICK edge; SAMPLE_VALID rises the following cycle, i.e. 1-cycle latency into an empty FIFO.
  - Pop happens when SAMPLE_VALID & SAMPLE_READY at a clock edge. Head data/channel are stable while VALID=1 and READY=0.
  - Push and pop in the same cycle: both succeed and the level is unchanged. This includes the full case, so the push is accepted when full if a pop happens that cycle.
  - Push when full without a pop: the sample is dropped and OVERRUN is set; P still advances. OVERRUN clears only on reset.
  - Pop when empty: no effect.
- FIFO_LEVEL is registered and exact every cycle, range 0..FIFO_DEPTH.

Optional Feature:
- Macro DAC_WAVE_BACKPRESSURE_EN.
- Defined:
  - When a tick would occur with the FIFO full and no pop, the counter holds at SAMPLE_DIV-1 and P is frozen.
  - The tick fires on the first cycle where space exists or a pop occurs.
  - No sample is ever dropped; OVERRUN is tied to 0.
- Undefined: drop-and-flag behaviour as specified above.

Test Plan:
- Sawtooth: SAMPLE_DIV=4, STEP=0x400, READY=1, ENABLE=1 -> accepted samples 0x000, 0x400, 0x800, 0xC00, 0x000 (wrap); each VALID one cycle after its tick; CHANNEL=4'h2 on all; COMMAND=4'b0011.
- Triangle: STEP=0x600 -> 0x000, 0x600, 0xC00, 0xFFF, 0x9FF, 0x3FF, 0x000, 0x600.
- Square: STEP=0x800, LEVEL=0x123 -> 0x000, 0x123, 0x000, 0x123; MODE switched to constant mid-run with LEVEL=0x0AB -> 0x0AB on all following samples, P retained.
- Overrun: READY=0 for 5 ticks -> FIFO_LEVEL=4 and OVERRUN=1 after the 5th tick; then READY=1 -> 0x000, 0x400, 0x800, 0xC00 in order; OVERRUN stays 1. With DAC_WAVE_BACKPRESSURE_EN: OVERRUN stays 0 and the 5th sample 0x000 follows after the stall.
- Full with simultaneous pop: FIFO full, READY pulsed on the tick cycle -> push accepted, level stays 4, no OVERRUN.
- Reset mid-operation: RESET_N low asynchronously with FIFO_LEVEL=3 -> VALID=0 and level 0 before the next edge; after release the first sample is 0x000 and triangle DIR=up. Separately, ENABLE=0 for 20 cycles -> no pushes; ENABLE=1 resumes from the retained P.
